// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch and load/store) in front of a single-port
// data memory: round-robin grant, fixed-length access sequencing, per-port completion pulses.
module mem_port_arbiter #(
    parameter int WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic        IFReq,
    input  logic [31:0] IFAddress,
    output logic [31:0] IFReadData,
    output logic        IFDone,
    output logic        StallIF,

    input  logic        MEMRead,
    input  logic        MEMWrite,
    input  logic [31:0] MEMAddress,
    input  logic [31:0] MEMWriteData,
    output logic [31:0] MEMReadData,
    output logic        MEMDone,
    output logic        StallMEM,

    output logic [31:0] DMAddress,
    output logic [31:0] DMWriteData,
    output logic        DMMemRead,
    output logic        DMMemWrite,
    input  logic [31:0] DMReadData
);

    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUSY_IF  = 2'd1,
        BUSY_MEM = 2'd2
    } state_t;

    state_t        state_q,     state_d;
    logic          last_mem_q,  last_mem_d;
    logic [CW-1:0] cnt_q,       cnt_d;
    logic [31:0]   addr_q,      addr_d;
    logic [31:0]   wdata_q,     wdata_d;
    logic          is_write_q,  is_write_d;
    logic          if_done_q,   if_done_d;
    logic          mem_done_q,  mem_done_d;
    logic [31:0]   if_rdata_q,  if_rdata_d;
    logic [31:0]   mem_rdata_q, mem_rdata_d;

    logic mem_req;
    logic if_pend;
    logic mem_pend;
    logic grant_mem;
    logic grant_if;
    logic last_cnt;
    logic busy;

    // A requester still holding its request during its own Done cycle is stale.
    assign mem_req   = MEMRead | MEMWrite;
    assign if_pend   = IFReq & ~if_done_q;
    assign mem_pend  = mem_req & ~mem_done_q;
    assign grant_mem = mem_pend & (~if_pend | ~last_mem_q);
    assign grant_if  = if_pend & ~grant_mem;
    assign last_cnt  = (cnt_q == '0);
    assign busy      = (state_q != IDLE);

    always_comb begin
        state_d     = state_q;
        last_mem_d  = last_mem_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        is_write_d  = is_write_q;
        if_done_d   = 1'b0;
        mem_done_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;

        case (state_q)
            IDLE: begin
                if (grant_mem) begin
                    state_d    = BUSY_MEM;
                    addr_d     = MEMAddress;
                    wdata_d    = MEMWriteData;
                    is_write_d = MEMWrite;
                    cnt_d      = CNT_LOAD;
                    last_mem_d = 1'b1;
                end else if (grant_if) begin
                    state_d    = BUSY_IF;
                    addr_d     = IFAddress;
                    wdata_d    = '0;
                    is_write_d = 1'b0;
                    cnt_d      = CNT_LOAD;
                    last_mem_d = 1'b0;
                end
            end

            BUSY_IF: begin
                if (!IFReq) begin
                    state_d = IDLE;
                end else if (last_cnt) begin
                    state_d    = IDLE;
                    if_done_d  = 1'b1;
                    if_rdata_d = DMReadData;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            BUSY_MEM: begin
                if (!mem_req) begin
                    state_d = IDLE;
                end else if (last_cnt) begin
                    state_d    = IDLE;
                    mem_done_d = 1'b1;
                    if (!is_write_q) begin
                        mem_rdata_d = DMReadData;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= IDLE;
            last_mem_q  <= 1'b0;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            is_write_q  <= 1'b0;
            if_done_q   <= 1'b0;
            mem_done_q  <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_mem_q  <= last_mem_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            is_write_q  <= is_write_d;
            if_done_q   <= if_done_d;
            mem_done_q  <= mem_done_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Memory-side controls decode only registered state, so reset clears them at once.
    // The write strobe also needs the store still requested, so an abort never writes.
    assign DMAddress   = busy ? addr_q  : '0;
    assign DMWriteData = busy ? wdata_q : '0;
    assign DMMemRead   = busy & ~is_write_q;
    assign DMMemWrite  = (state_q == BUSY_MEM) & is_write_q & last_cnt & mem_req;

    assign IFReadData  = if_rdata_q;
    assign IFDone      = if_done_q;
    assign StallIF     = IFReq & ~if_done_q;
    assign MEMReadData = mem_rdata_q;
    assign MEMDone     = mem_done_q;
    assign StallMEM    = mem_req & ~mem_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: WAIT_CYCLES=2 instance with a small data memory
// model, plus a WAIT_CYCLES=1 fetch-only instance.
module tb_mem_port_arbiter;

    logic clk;
    logic rst;

    logic        if_req, mem_rd, mem_wr;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, dm_addr, dm_wdata, dm_rdata;
    logic        if_done, stall_if, mem_done, stall_mem, dm_rd, dm_wr;

    logic        b_if_req;
    logic [31:0] b_if_addr;
    logic [31:0] b_if_rdata, b_mem_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic        b_if_done, b_stall_if, b_mem_done, b_stall_mem, b_dm_rd, b_dm_wr;

    logic [31:0] mem [0:63];
    logic        mem_init;
    int          wr_cnt;
    int          wr0;
    int          n_chk;
    int          n_err;
    logic        got;

    mem_port_arbiter #(.WAIT_CYCLES(2)) dut_a (
        .Clk(clk), .Reset(rst),
        .IFReq(if_req), .IFAddress(if_addr), .IFReadData(if_rdata),
        .IFDone(if_done), .StallIF(stall_if),
        .MEMRead(mem_rd), .MEMWrite(mem_wr), .MEMAddress(mem_addr),
        .MEMWriteData(mem_wdata), .MEMReadData(mem_rdata),
        .MEMDone(mem_done), .StallMEM(stall_mem),
        .DMAddress(dm_addr), .DMWriteData(dm_wdata), .DMMemRead(dm_rd),
        .DMMemWrite(dm_wr), .DMReadData(dm_rdata)
    );

    mem_port_arbiter #(.WAIT_CYCLES(1)) dut_b (
        .Clk(clk), .Reset(rst),
        .IFReq(b_if_req), .IFAddress(b_if_addr), .IFReadData(b_if_rdata),
        .IFDone(b_if_done), .StallIF(b_stall_if),
        .MEMRead(1'b0), .MEMWrite(1'b0), .MEMAddress(32'h0),
        .MEMWriteData(32'h0), .MEMReadData(b_mem_rdata),
        .MEMDone(b_mem_done), .StallMEM(b_stall_mem),
        .DMAddress(b_dm_addr), .DMWriteData(b_dm_wdata), .DMMemRead(b_dm_rd),
        .DMMemWrite(b_dm_wr), .DMReadData(b_dm_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign dm_rdata   = mem[dm_addr[7:2]];
    assign b_dm_rdata = b_dm_addr ^ 32'h5A5A_0000;

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hC0DE_0000 | 32'(i);
        end else if (dm_wr) begin
            mem[dm_addr[7:2]] <= dm_wdata;
            wr_cnt            <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0; n_err = 0; wr_cnt = 0; wr0 = 0; got = 1'b0;
        rst = 1'b1; mem_init = 1'b1;
        if_req = 1'b0; if_addr = '0;
        mem_rd = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0;

        repeat (2) @(posedge clk);
        mid();
        check("rst_if_done",   if_done,   0);
        check("rst_mem_done",  mem_done,  0);
        check("rst_if_rdata",  if_rdata,  0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_dm_addr",   dm_addr,   0);
        check("rst_dm_rd",     dm_rd,     0);
        check("rst_dm_wr",     dm_wr,     0);
        check("rst_b_done",    b_if_done, 0);
        tick(); rst = 1'b0; mem_init = 1'b0;

        // single load, latency and stall profile
        tick(); mem_rd = 1'b1; mem_addr = 32'h10;
        mid();  check("t1_stall_c1", stall_mem, 1); check("t1_dmrd_c1", dm_rd, 0);
        tick(); mid();
        check("t1_dmrd_c2", dm_rd, 1); check("t1_dmaddr_c2", dm_addr, 32'h10);
        check("t1_done_c2", mem_done, 0);
        tick(); mid();
        check("t1_dmrd_c3", dm_rd, 1); check("t1_stall_c3", stall_mem, 1);
        tick(); mid();
        check("t1_done_c4", mem_done, 1); check("t1_rdata_c4", mem_rdata, 32'hC0DE_0004);
        check("t1_stall_c4", stall_mem, 0); check("t1_dmrd_c4", dm_rd, 0);
        tick(); mem_rd = 1'b0;
        mid();  check("t1_done_c5", mem_done, 0); check("t1_rdata_hold", mem_rdata, 32'hC0DE_0004);

        // store, single write strobe on latched values, then fetch readback
        tick(); wr0 = wr_cnt; mem_wr = 1'b1; mem_addr = 32'h20; mem_wdata = 32'hDEAD_BEEF;
        mid();  check("t2_dmwr_c1", dm_wr, 0);
        tick(); mem_addr = 32'h30; mem_wdata = 32'h1111_1111;
        mid();  check("t2_dmwr_c2", dm_wr, 0); check("t2_dmaddr_c2", dm_addr, 32'h20);
        tick(); mid();
        check("t2_dmwr_c3", dm_wr, 1); check("t2_dmaddr_c3", dm_addr, 32'h20);
        check("t2_dmwdata_c3", dm_wdata, 32'hDEAD_BEEF);
        tick(); mid();
        check("t2_done_c4", mem_done, 1); check("t2_dmwr_c4", dm_wr, 0);
        check("t2_rdata_unch", mem_rdata, 32'hC0DE_0004);
        tick(); mem_wr = 1'b0;
        mid();  check("t2_wr_count", wr_cnt - wr0, 1); check("t2_mem_word", mem[8], 32'hDEAD_BEEF);
        tick(); if_req = 1'b1; if_addr = 32'h20;
        tick(); tick(); tick(); mid();
        check("t2_ifdone", if_done, 1); check("t2_ifrdata", if_rdata, 32'hDEAD_BEEF);
        check("t2_stallif", stall_if, 0);
        tick(); if_req = 1'b0;

        // contention from reset: MEM first, then strict alternation
        tick(); rst = 1'b1;
        mid();  check("t3_rst_ifrdata", if_rdata, 0);
        tick(); rst = 1'b0;
        tick(); if_req = 1'b1; if_addr = 32'h20; mem_rd = 1'b1; mem_addr = 32'h10;
        mid();  check("t3_stallif_c1", stall_if, 1); check("t3_stallmem_c1", stall_mem, 1);
        tick(); mid();
        check("t3_dmaddr_c2", dm_addr, 32'h10); check("t3_dmrd_c2", dm_rd, 1);
        tick();
        tick(); mid();
        check("t3_memdone_c4", mem_done, 1); check("t3_ifdone_c4", if_done, 0);
        check("t3_stallif_c4", stall_if, 1); check("t3_memrdata_c4", mem_rdata, 32'hC0DE_0004);
        tick(); mid(); check("t3_dmaddr_c5", dm_addr, 32'h20);
        tick();
        tick(); mid();
        check("t3_ifdone_c7", if_done, 1); check("t3_memdone_c7", mem_done, 0);
        check("t3_ifrdata_c7", if_rdata, 32'hDEAD_BEEF);
        for (int k = 8; k <= 13; k++) begin
            tick(); mid();
            check("t3_overlap", {31'b0, if_done & mem_done}, 0);
            if (k == 8)  check("t3_dmaddr_c8", dm_addr, 32'h10);
            if (k == 10) check("t3_memdone_c10", mem_done, 1);
            if (k == 11) check("t3_dmaddr_c11", dm_addr, 32'h20);
            if (k == 13) check("t3_ifdone_c13", if_done, 1);
        end
        tick(); if_req = 1'b0; mem_rd = 1'b0;
        tick(); mid(); check("t3_abort_done", mem_done, 0); check("t3_abort_dmrd", dm_rd, 0);
        tick(); mid(); check("t3_abort_done2", mem_done, 0);

        // fetch dropped while busy
        tick(); if_req = 1'b1; if_addr = 32'h10;
        tick(); if_req = 1'b0;
        mid();  check("t4_dmrd_c2", dm_rd, 1); check("t4_dmaddr_c2", dm_addr, 32'h10);
        tick(); mid();
        check("t4_dmrd_c3", dm_rd, 0); check("t4_ifdone_c3", if_done, 0);
        tick(); mid();
        check("t4_ifdone_c4", if_done, 0); check("t4_ifrdata_keep", if_rdata, 32'hDEAD_BEEF);

        // reset in the final cycle of a store
        tick(); wr0 = wr_cnt; mem_wr = 1'b1; mem_addr = 32'h30; mem_wdata = 32'hCAFE_F00D;
        tick(); mid(); check("t5_dmaddr_c2", dm_addr, 32'h30);
        tick(); rst = 1'b1;
        mid();  check("t5_dmwr_rst", dm_wr, 0); check("t5_dmaddr_rst", dm_addr, 0);
        check("t5_dmrd_rst", dm_rd, 0);
        tick(); rst = 1'b0; mem_wr = 1'b0;
        mid();
        check("t5_mem_word", mem[12], 32'hC0DE_000C); check("t5_no_write", wr_cnt - wr0, 0);
        check("t5_memrdata", mem_rdata, 0); check("t5_memdone", mem_done, 0);
        tick(); if_req = 1'b1; if_addr = 32'h20; mem_rd = 1'b1; mem_addr = 32'h10;
        tick(); mid();
        check("t5_grant_mem", dm_addr, 32'h10); check("t5_grant_rd", dm_rd, 1);
        tick(); if_req = 1'b0; mem_rd = 1'b0;
        tick(); tick();

        // single-cycle access, continuous fetch with advancing address
        tick(); b_if_req = 1'b1; b_if_addr = 32'h100;
        mid();  check("t6_idle_addr", b_dm_addr, 0);
        tick(); mid();
        check("t6_dmaddr_c2", b_dm_addr, 32'h100); check("t6_dmrd_c2", b_dm_rd, 1);
        tick(); mid();
        check("t6_done_c3", b_if_done, 1); check("t6_rdata_c3", b_if_rdata, 32'h5A5A_0100);
        tick(); b_if_addr = 32'h104;
        got = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mid();
            if (!got && b_dm_rd) check("t6_track", b_dm_addr, 32'h104);
            if (!got && b_if_done) begin
                got = 1'b1;
                check("t6_rdata2", b_if_rdata, 32'h5A5A_0104);
            end
            tick();
        end
        check("t6_second_done", {31'b0, got}, 1);
        b_if_req = 1'b0;
        tick(); tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
